// File: rtl/zx_tape_pkg.sv
// Shared definitions for the ZX81 tape player (and the future tape saver):
// FSM state encoding, default 6.5 MHz timing constants and pulse counts.
package zx_tape_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeader,
    StFetch,
    StPulseHi,
    StPulseLo,
    StGap,
    StDone
  } tape_state_e;

  // Default timing at a 6.5 MHz core clock.
  localparam int unsigned PulseCyc = 975;      // 150 us pulse half-period
  localparam int unsigned GapCyc   = 8450;     // 1300 us silence after each bit
  localparam int unsigned LeadCyc  = 3250000;  // 0.5 s leader silence

  // Pulses per bit as used by the ZX81 ROM tape format.
  localparam logic [3:0] PulsesZero = 4'd4;
  localparam logic [3:0] PulsesOne  = 4'd9;

  function automatic logic [3:0] pulses_for_bit(input logic b);
    return b ? PulsesOne : PulsesZero;
  endfunction

endpackage

// File: rtl/p_tape_player.sv
// Plays a ZX81 .P image, fed as a valid/ready byte stream, as a tape waveform
// on tape_out (high = pulse high). Bits MSB first, one down counter for all
// phase timing.
module p_tape_player
  import zx_tape_pkg::*;
#(
  parameter int unsigned PULSE_CYC = PulseCyc,
  parameter int unsigned GAP_CYC   = GapCyc,
  parameter int unsigned LEAD_CYC  = LeadCyc,
  parameter int unsigned CNT_W     = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tape_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  // Timer loads: a phase of N cycles loads N-1 and exits when the timer reads 0.
  localparam logic [CNT_W-1:0] PulseLoad = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GapLoad   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] LeadLoad  = CNT_W'(LEAD_CYC - 1);

  tape_state_e      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       pulses_q, pulses_d;
  logic             underrun_q, underrun_d;
  logic             tape_q, tape_d;
  logic             from_gap_q, from_gap_d;  // FETCH is waiting for a non-first byte
  logic             start_q;
  logic             start_edge;
  logic             timer_zero;
  logic [2:0]       nxt_idx;

  assign start_edge = start & ~start_q;
  assign timer_zero = (timer_q == '0);
  assign nxt_idx    = bit_idx_q - 3'd1;

  // Next-state, timer and datapath updates.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_zero ? timer_q : timer_q - CNT_W'(1);
    byte_d     = byte_q;
    last_d     = last_q;
    bit_idx_d  = bit_idx_q;
    pulses_d   = pulses_q;
    underrun_d = underrun_q;
    from_gap_d = from_gap_q;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d    = StLeader;
          timer_d    = LeadLoad;
          underrun_d = 1'b0;
        end
      end
      StLeader: begin
        if (timer_zero) begin
          state_d    = StFetch;
          from_gap_d = 1'b0;
          timer_d    = '0;
        end
      end
      StFetch: begin
        if (in_valid) begin
          byte_d    = in_data;
          last_d    = in_last;
          bit_idx_d = 3'd7;
          pulses_d  = pulses_for_bit(in_data[7]);
          state_d   = StPulseHi;
          timer_d   = PulseLoad;
        end else if (from_gap_q && timer_zero) begin
          // Source missed the inter-byte slot; keep waiting, flag it.
          underrun_d = 1'b1;
        end
      end
      StPulseHi: begin
        if (timer_zero) begin
          state_d = StPulseLo;
          timer_d = PulseLoad;
        end
      end
      StPulseLo: begin
        if (timer_zero) begin
          pulses_d = pulses_q - 4'd1;
          if (pulses_q == 4'd1) begin
            state_d = StGap;
            timer_d = GapLoad;
          end else begin
            state_d = StPulseHi;
            timer_d = PulseLoad;
          end
        end
      end
      StGap: begin
        if (timer_zero) begin
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = nxt_idx;
            pulses_d  = pulses_for_bit(byte_q[nxt_idx]);
            state_d   = StPulseHi;
            timer_d   = PulseLoad;
          end else if (last_q) begin
            state_d = StDone;
          end else begin
            state_d    = StFetch;
            from_gap_d = 1'b1;
            timer_d    = GapLoad;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Stop overrides everything, including a simultaneous start edge.
    if (stop) begin
      state_d    = StIdle;
      underrun_d = underrun_q;
    end

    tape_d = (state_d == StPulseHi);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      bit_idx_q  <= '0;
      pulses_q   <= '0;
      underrun_q <= 1'b0;
      tape_q     <= 1'b0;
      from_gap_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      bit_idx_q  <= bit_idx_d;
      pulses_q   <= pulses_d;
      underrun_q <= underrun_d;
      tape_q     <= tape_d;
      from_gap_q <= from_gap_d;
      start_q    <= start;
    end
  end

  assign in_ready = (state_q == StFetch);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign tape_out = tape_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_p_tape_player.sv
// Self-checking bench for p_tape_player with short timing (pulse 4, gap 10,
// leader 20). Outputs are sampled on the falling clock edge.
module tb_p_tape_player;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready, tape_out, busy, done, underrun;

  int checks = 0;
  int failures = 0;

  p_tape_player #(
    .PULSE_CYC(4),
    .GAP_CYC  (10),
    .LEAD_CYC (20),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_last (in_last),
    .in_ready(in_ready),
    .tape_out(tape_out),
    .busy    (busy),
    .done    (done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         rises;
    int         highs;
    int         cyc;
  } byte_vec_t;

  byte_vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start edge at the next rising clock; returns in LEADER cycle 1.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts low busy cycles from the current one until in_ready appears.
  task automatic wait_fetch(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) break;
      if (busy && !tape_out) n++;
      @(negedge clk);
    end
  endtask

  // Offers one byte from FETCH and measures its waveform until FETCH or DONE.
  task automatic play_byte(input logic [7:0] d, input logic l,
                           output int rises, output int highs, output int cyc);
    logic prev;
    prev  = 1'b0;
    rises = 0;
    highs = 0;
    cyc   = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (in_ready || done) break;
      cyc++;
      if (tape_out) highs++;
      if (tape_out && !prev) rises++;
      prev = tape_out;
    end
  endtask

  int n, r, h, c, cnt;
  logic prev_t;

  initial begin
    // Hand-computed: bit1 = 9 pulses (82 cycles), bit0 = 4 pulses (42 cycles).
    vecs[0] = '{8'h00, 1'b0, 32, 128, 336};
    vecs[1] = '{8'hA5, 1'b0, 52, 208, 496};
    vecs[2] = '{8'h80, 1'b0, 37, 148, 376};
    vecs[3] = '{8'hFF, 1'b1, 72, 288, 656};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tape", int'(tape_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(in_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_underrun", int'(underrun), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Playback 1: byte offered during LEADER must wait; back-to-back bytes
    in_data  = 8'h00;
    in_last  = 1'b0;
    in_valid = 1'b1;
    pulse_start();
    check("leader_busy", int'(busy), 1);
    wait_fetch(n);
    check("leader_len", n, 20);
    for (int i = 0; i < 4; i++) begin
      play_byte(vecs[i].data, vecs[i].last, r, h, c);
      check($sformatf("v%0d_rises", i), r, vecs[i].rises);
      check($sformatf("v%0d_highs", i), h, vecs[i].highs);
      check($sformatf("v%0d_cycles", i), c, vecs[i].cyc);
      if (vecs[i].last) begin
        check($sformatf("v%0d_done", i), int'(done), 1);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", i), int'(done), 0);
        check($sformatf("v%0d_busy_after", i), int'(busy), 0);
      end else begin
        check($sformatf("v%0d_fetch_ready", i), int'(in_ready), 1);
        check($sformatf("v%0d_fetch_low", i), int'(tape_out), 0);
      end
    end

    // Playback 2: underrun after GAP_CYC waiting cycles
    pulse_start();
    wait_fetch(n);
    check("leader_len2", n, 20);
    play_byte(8'h00, 1'b0, r, h, c);
    check("ur_first_cycles", c, 336);
    check("ur_fetch1", int'(underrun), 0);
    for (int k = 2; k <= 11; k++) begin
      @(negedge clk);
      check($sformatf("ur_fetch%0d", k), int'(underrun), (k == 11) ? 1 : 0);
    end
    check("ur_still_low", int'(tape_out), 0);
    play_byte(8'h80, 1'b1, r, h, c);
    check("ur_byte_rises", r, 37);
    check("ur_byte_cycles", c, 376);
    check("ur_byte_done", int'(done), 1);
    @(negedge clk);
    check("ur_idle", int'(busy), 0);
    check("ur_sticky", int'(underrun), 1);

    // start and stop together: stop wins, underrun kept
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    check("startstop_busy", int'(busy), 0);
    check("startstop_underrun", int'(underrun), 1);
    stop = 1'b0;
    repeat (2) @(negedge clk);
    check("start_held_no_edge", int'(busy), 0);
    start = 1'b0;
    @(negedge clk);
    pulse_start();
    check("ur_cleared", int'(underrun), 0);
    check("restart_busy", int'(busy), 1);

    // Playback 3: stop during the 3rd pulse
    wait_fetch(n);
    check("leader_len3", n, 20);
    in_data  = 8'h00;
    in_last  = 1'b0;
    in_valid = 1'b1;
    r = 0;
    prev_t = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (tape_out && !prev_t) r++;
      prev_t = tape_out;
      if (r == 3) break;
    end
    check("stop_third_pulse", r, 3);
    stop = 1'b1;
    @(negedge clk);
    check("stop_busy", int'(busy), 0);
    check("stop_tape", int'(tape_out), 0);
    check("stop_ready", int'(in_ready), 0);
    stop = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) cnt++;
      @(negedge clk);
    end
    check("stop_no_done", cnt, 0);

    // Playback 4: asynchronous reset mid PULSE_HI
    pulse_start();
    wait_fetch(n);
    in_data  = 8'hFF;
    in_last  = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("pulse_hi_entered", int'(tape_out), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_tape", int'(tape_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ready", int'(in_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || tape_out) cnt++;
    end
    check("arst_stays_idle", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
